// File: rtl/if_fetch_unit.sv
// if_fetch_unit: single-outstanding instruction fetch stage with an IF/ID holding register.
// Optional build macro FETCH_MISALIGN_CHK_EN: a misaligned PC target raises a sticky
// misalign_err and parks the unit in HALT until reset. When the macro is undefined,
// targets are force-aligned and misalign_err is tied low.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] npc,
    input  logic        redirect,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    input  logic        id_ready,
    output logic        misalign_err
);

    localparam int unsigned XLEN     = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

`ifdef FETCH_MISALIGN_CHK_EN
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2,
        S_HALT  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2
    } state_t;
`endif

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_imem_req;
    logic            r_if_valid;
    logic [XLEN-1:0] r_if_pc;
    logic [XLEN-1:0] r_if_inst;
    logic [XLEN-1:0] w_npc_aligned;

    // Word-aligned view of the incoming next-PC
    assign w_npc_aligned = npc & ALIGN_MASK;

`ifdef FETCH_MISALIGN_CHK_EN
    logic r_misalign_err;
    assign misalign_err = r_misalign_err;
`else
    assign misalign_err = 1'b0;
`endif

    assign pc        = r_pc;
    assign imem_addr = r_pc;
    assign imem_req  = r_imem_req;
    assign if_valid  = r_if_valid;
    assign if_pc     = r_if_pc;
    assign if_inst   = r_if_inst;

    // PC update: load npc and move to ok_state, unless the target traps into HALT
    task automatic pc_update(input state_t ok_state, input logic ok_req);
`ifdef FETCH_MISALIGN_CHK_EN
        if (npc[1:0] != 2'b00) begin
            r_misalign_err <= 1'b1;
            r_if_valid     <= 1'b0;
            r_imem_req     <= 1'b0;
            r_state        <= S_HALT;
        end else
`endif
        begin
            r_pc       <= w_npc_aligned;
            r_imem_req <= ok_req;
            r_state    <= ok_state;
        end
    endtask

    // Fetch FSM with registered request and IF/ID holding register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC;
            r_imem_req <= 1'b1;
            r_if_valid <= 1'b0;
            r_if_pc    <= '0;
            r_if_inst  <= NOP_INST;
`ifdef FETCH_MISALIGN_CHK_EN
            r_misalign_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (redirect) begin
                        // A response arriving with the redirect is stale; otherwise drain it in DROP
                        pc_update(imem_rvalid ? S_FETCH : S_DROP, imem_rvalid);
                    end else if (imem_rvalid) begin
                        r_if_inst  <= imem_rdata;
                        r_if_pc    <= r_pc;
                        r_if_valid <= 1'b1;
                        r_imem_req <= 1'b0;
                        r_state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // Redirect and accept both release the held word; redirect wins the PC choice
                    if (redirect || id_ready) begin
                        r_if_valid <= 1'b0;
                        pc_update(S_FETCH, 1'b1);
                    end
                end
                S_DROP: begin
                    if (redirect) begin
                        pc_update(imem_rvalid ? S_FETCH : S_DROP, imem_rvalid);
                    end else if (imem_rvalid) begin
                        r_imem_req <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
`ifdef FETCH_MISALIGN_CHK_EN
                S_HALT: begin
                    r_imem_req <= 1'b0;
                    r_state    <= S_HALT;
                end
`endif
                default: begin
                    r_imem_req <= 1'b1;
                    r_state    <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit; expectations follow FETCH_MISALIGN_CHK_EN when defined.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] npc;
    logic        redirect;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        id_ready;
    logic        misalign_err;

    logic        zw;
    logic        auto_npc;
    logic        man_rvalid;
    logic [31:0] man_npc;
    logic [31:0] man_rdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Zero-wait memory answers in the request cycle; data encodes its address
    always_comb begin
        npc         = auto_npc ? (pc + 32'd4) : man_npc;
        imem_rvalid = zw ? imem_req : man_rvalid;
        imem_rdata  = zw ? ((imem_addr << 12) | 32'h0000_0093) : man_rdata;
    end

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .npc          (npc),
        .redirect     (redirect),
        .pc           (pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_rvalid  (imem_rvalid),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .id_ready     (id_ready),
        .misalign_err (misalign_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1; redirect = 1'b0; id_ready = 1'b0; zw = 1'b0; auto_npc = 1'b1;
        man_rvalid = 1'b0; man_npc = '0; man_rdata = '0;
        #2 rst_n = 1'b0;
        tick; tick;
        check("rst_pc",    pc,           32'h0);
        check("rst_valid", {31'b0, if_valid}, 32'h0);
        check("rst_ifpc",  if_pc,        32'h0);
        check("rst_inst",  if_inst,      32'h0000_0013);
        check("rst_err",   {31'b0, misalign_err}, 32'h0);

        // Sequential fetch, zero-wait memory, decode always ready
        zw = 1'b1; id_ready = 1'b1; rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("seq_req",   {31'b0, imem_req}, 32'h1);
            check("seq_addr",  imem_addr, 32'(4 * k));
            tick;
            check("seq_valid", {31'b0, if_valid}, 32'h1);
            check("seq_ifpc",  if_pc, 32'(4 * k));
            check("seq_inst",  if_inst, (32'(4 * k) << 12) | 32'h93);
            check("seq_hreq",  {31'b0, imem_req}, 32'h0);
            tick;
        end

        // Decode stall: held word must not move, late rvalid ignored
        zw = 1'b0; id_ready = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h00A0_0093;
        tick;
        man_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {31'b0, if_valid}, 32'h1);
            check("stall_ifpc",  if_pc, 32'h0000_000C);
            check("stall_inst",  if_inst, 32'h00A0_0093);
            check("stall_req",   {31'b0, imem_req}, 32'h0);
            tick;
        end
        man_rvalid = 1'b0; id_ready = 1'b1;
        tick;
        check("rel_pc",    pc, 32'h0000_0010);
        check("rel_valid", {31'b0, if_valid}, 32'h0);
        check("rel_req",   {31'b0, imem_req}, 32'h1);
        id_ready = 1'b0;

        // Redirect while waiting; second redirect in DROP supersedes the first
        auto_npc = 1'b0; redirect = 1'b1; man_npc = 32'h0000_0040;
        tick;
        check("drop_req",  {31'b0, imem_req}, 32'h0);
        check("drop_pc",   pc, 32'h0000_0040);
        man_npc = 32'h0000_0100;
        tick;
        redirect = 1'b0;
        check("drop_pc2",  pc, 32'h0000_0100);
        check("drop_req2", {31'b0, imem_req}, 32'h0);
        tick;
        man_rvalid = 1'b1; man_rdata = 32'hBAD0_BAD0;
        check("drop_valid", {31'b0, if_valid}, 32'h0);
        tick;
        man_rvalid = 1'b0;
        check("drop_exit_req",  {31'b0, imem_req}, 32'h1);
        check("drop_exit_addr", imem_addr, 32'h0000_0100);
        check("drop_exit_valid", {31'b0, if_valid}, 32'h0);
        tick;
        check("drop_stale_valid", {31'b0, if_valid}, 32'h0);
        check("drop_stale_req",   {31'b0, imem_req}, 32'h1);

        // Redirect and id_ready together in HOLD
        man_rvalid = 1'b1; man_rdata = 32'h0000_0011;
        tick;
        man_rvalid = 1'b0;
        check("both_valid", {31'b0, if_valid}, 32'h1);
        check("both_ifpc",  if_pc, 32'h0000_0100);
        redirect = 1'b1; id_ready = 1'b1; man_npc = 32'h0000_0200;
        tick;
        redirect = 1'b0; id_ready = 1'b0;
        check("both_valid2", {31'b0, if_valid}, 32'h0);
        check("both_req",    {31'b0, imem_req}, 32'h1);
        check("both_addr",   imem_addr, 32'h0000_0200);

        // Redirect coincident with the response: discard, stay in FETCH
        redirect = 1'b1; man_rvalid = 1'b1; man_rdata = 32'h0000_0022; man_npc = 32'h0000_0300;
        tick;
        redirect = 1'b0; man_rvalid = 1'b0;
        check("rr_req",   {31'b0, imem_req}, 32'h1);
        check("rr_addr",  imem_addr, 32'h0000_0300);
        check("rr_valid", {31'b0, if_valid}, 32'h0);
        check("rr_inst",  if_inst, 32'h0000_0011);

        // Misaligned target
        redirect = 1'b1; man_npc = 32'h0000_0102;
        tick;
        redirect = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        check("mis_err", {31'b0, misalign_err}, 32'h1);
        check("mis_req", {31'b0, imem_req}, 32'h0);
        check("mis_pc",  pc, 32'h0000_0300);
        man_rvalid = 1'b1; id_ready = 1'b1; redirect = 1'b1; man_npc = 32'h0000_0400;
        repeat (3) tick;
        check("halt_err",   {31'b0, misalign_err}, 32'h1);
        check("halt_req",   {31'b0, imem_req}, 32'h0);
        check("halt_pc",    pc, 32'h0000_0300);
        check("halt_valid", {31'b0, if_valid}, 32'h0);
        redirect = 1'b0; man_rvalid = 1'b0; id_ready = 1'b0;
`else
        check("mis_err", {31'b0, misalign_err}, 32'h0);
        check("mis_pc",  pc, 32'h0000_0100);
        check("mis_req", {31'b0, imem_req}, 32'h0);
        man_rvalid = 1'b1; man_rdata = 32'h0000_0033;
        tick;
        tick;
        man_rvalid = 1'b0;
        check("mis_valid", {31'b0, if_valid}, 32'h1);
        check("mis_ifpc",  if_pc, 32'h0000_0100);
        check("mis_inst",  if_inst, 32'h0000_0033);
`endif

        // Asynchronous reset pulse mid-operation
        rst_n = 1'b0;
        #1;
        check("arst_pc",    pc, 32'h0);
        check("arst_valid", {31'b0, if_valid}, 32'h0);
        check("arst_ifpc",  if_pc, 32'h0);
        check("arst_inst",  if_inst, 32'h0000_0013);
        check("arst_err",   {31'b0, misalign_err}, 32'h0);
        rst_n = 1'b1;
        tick;
        check("arst_req",  {31'b0, imem_req}, 32'h1);
        check("arst_addr", imem_addr, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded at reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 npc  input  32  next-PC from the next-PC generator; sampled only on a PC-update cycle.
REQ-005 redirect  input  1  taken jal/jalr/branch resolved downstream; flushes the fetch in flight.
REQ-006 pc  output  32  current fetch PC; feeds the next-PC generator's sequential path.
REQ-007 imem_req  output  1  instruction-memory request, level-held until response.
REQ-008 imem_addr  output  32  request address; equals pc.
REQ-009 imem_rdata  input  32  instruction word; valid only with imem_rvalid.
REQ-010 imem_rvalid  input  1  one-cycle response strobe for the single outstanding request.
REQ-011 if_valid  output  1  IF/ID register holds a valid instruction.
REQ-012 if_pc  output  32  PC of the held instruction.
REQ-013 if_inst  output  32  held instruction word.
REQ-014 id_ready  input  1  decode accepts the held instruction this cycle.
REQ-015 misalign_err  output  1  sticky misaligned-target flag (see Configuration).

Function
REQ-016 FSM states SHALL be FETCH, HOLD, DROP and, when configured, HALT.
REQ-017 At most one imem request SHALL be outstanding; imem_req=1 only in FETCH; imem_addr SHALL remain stable while imem_req=1.
REQ-018 "PC update" SHALL mean: pc <= npc on that edge; no other path SHALL modify pc after reset.
REQ-019 FETCH, imem_rvalid=1, redirect=0: if_inst<=imem_rdata, if_pc<=pc, if_valid<=1, go HOLD; pc unchanged.
REQ-020 FETCH, redirect=1, imem_rvalid=1: discard response, PC update, stay FETCH.
REQ-021 FETCH, redirect=1, imem_rvalid=0: PC update, go DROP.
REQ-022 FETCH, neither: hold state, request, and pc.
REQ-023 HOLD: imem_req=0; redirect or id_ready -> if_valid<=0, PC update, go FETCH; redirect takes priority over id_ready, and the held instruction SHALL NOT count as accepted when both are high.
REQ-024 HOLD, neither: all outputs stable.
REQ-025 DROP: imem_req=0; imem_rvalid=1 -> discard, go FETCH; redirect=1 in same or earlier cycle -> PC update (latest npc wins).
REQ-026 imem_rvalid SHALL be ignored in HOLD and HALT.
REQ-027 Minimum fetch-to-fetch spacing SHALL be 2 cycles (zero-wait memory, id_ready held high).

Reset
REQ-028 On rst_n=0: state=FETCH, pc=RESET_PC, if_valid=0, if_pc=0, if_inst=32'h0000_0013 (NOP), misalign_err=0, asynchronously.
REQ-029 First imem_req=1 SHALL appear in the first cycle after rst_n deasserts; reset mid-request SHALL abandon the request and drop any later response.

Configuration
REQ-030 Macro FETCH_MISALIGN_CHK_EN defined: a PC update with npc[1:0]!=0 SHALL set misalign_err=1, leave pc unchanged, clear if_valid, enter HALT (imem_req=0) until reset.
REQ-031 Macro undefined: PC update SHALL load {npc[31:2],2'b00}; misalign_err tied 0; no HALT state.

Verification
REQ-032 Reset release, RESET_PC=0, zero-wait memory, id_ready=1, npc=pc+4 -> imem_addr 0,4,8 on cycles 1,3,5; if_valid pulses carry matching if_pc.
REQ-033 Hold id_ready=0 for 5 cycles in HOLD with if_inst=32'h00A00093 -> if_valid, if_pc, if_inst stable, imem_req=0 throughout.
REQ-034 redirect=1, npc=32'h0000_0100 while FETCH waiting (rvalid 3 cycles later) -> DROP, response discarded, next imem_addr=32'h100, no if_valid for stale word.
REQ-035 HOLD with redirect=1 and id_ready=1 same cycle, npc=32'h200 -> if_valid=0 next cycle, next imem_addr=32'h200.
REQ-036 With FETCH_MISALIGN_CHK_EN, npc=32'h0000_0102 on update -> misalign_err=1, imem_req=0 permanently; rst_n pulse clears to pc=RESET_PC.
REQ-037 Without macro, same stimulus -> pc=32'h0000_0100, misalign_err=0.
